// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register and operand formation ahead of the ALU.
// Holds one decoded instruction, resolves MEM/WB forwarding on the held
// register values, and selects the A/B operands. It also detects load-use
// hazards, inserts bubbles, and applies stall/flush from the hazard unit.
module ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs1_addr,
  input  logic [4:0]        id_rs2_addr,
  input  logic [4:0]        id_rd_addr,
  input  logic [CTRL_W-1:0] id_alu_ctrl,
  input  logic              id_src_a_sel,
  input  logic              id_src_b_sel,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_fwd_en,
  input  logic [4:0]        mem_fwd_rd,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic              wb_fwd_en,
  input  logic [4:0]        wb_fwd_rd,
  input  logic [DATA_W-1:0] wb_fwd_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [CTRL_W-1:0] ex_alu_ctrl,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [DATA_W-1:0] ex_pc,
  output logic [4:0]        ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              load_use_stall
);

  localparam logic [CTRL_W-1:0] CTRL_ADD = CTRL_W'(2);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] rs1_val_q, rs1_val_d;
  logic [DATA_W-1:0] rs2_val_q, rs2_val_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [4:0]        rs1_addr_q, rs1_addr_d;
  logic [4:0]        rs2_addr_q, rs2_addr_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              src_a_sel_q, src_a_sel_d;
  logic              src_b_sel_q, src_b_sel_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;

  logic [DATA_W-1:0] fwd_rs1, fwd_rs2;

  // MEM beats WB; x0 never matches so it always reads its held value.
  function automatic logic [DATA_W-1:0] fwd_sel(input logic [4:0]        addr,
                                                input logic [DATA_W-1:0] held);
    if (mem_fwd_en && mem_fwd_rd == addr && addr != 5'd0)     return mem_fwd_data;
    else if (wb_fwd_en && wb_fwd_rd == addr && addr != 5'd0)  return wb_fwd_data;
    else                                                      return held;
  endfunction

  // Forwarding, operand selection and hazard detection off the held state.
  always_comb begin
    fwd_rs1        = fwd_sel(rs1_addr_q, rs1_val_q);
    fwd_rs2        = fwd_sel(rs2_addr_q, rs2_val_q);
    ex_valid       = valid_q;
    ex_a           = src_a_sel_q ? pc_q  : fwd_rs1;
    ex_b           = src_b_sel_q ? imm_q : fwd_rs2;
    ex_store_data  = fwd_rs2;
    ex_alu_ctrl    = ctrl_q;
    ex_pc          = pc_q;
    ex_rd_addr     = rd_addr_q;
    ex_reg_write   = valid_q & reg_write_q;
    ex_mem_read    = valid_q & mem_read_q;
    ex_mem_write   = valid_q & mem_write_q;
    // Conservative: matches rs2 even for instructions that do not read it.
    load_use_stall = valid_q & mem_read_q & (rd_addr_q != 5'd0) & id_valid &
                     ((id_rs1_addr == rd_addr_q) | (id_rs2_addr == rd_addr_q));
  end

  // Next state: flush > stall (refresh forwarded values) > bubble > capture.
  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_val_d   = rs1_val_q;
    rs2_val_d   = rs2_val_q;
    imm_d       = imm_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rd_addr_d   = rd_addr_q;
    ctrl_d      = ctrl_q;
    src_a_sel_d = src_a_sel_q;
    src_b_sel_d = src_b_sel_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (stall) begin
      // A producer retiring during the hold must not be lost.
      rs1_val_d = fwd_rs1;
      rs2_val_d = fwd_rs2;
    end else if (load_use_stall) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else begin
      valid_d     = id_valid;
      pc_d        = id_pc;
      rs1_val_d   = id_rs1_data;
      rs2_val_d   = id_rs2_data;
      imm_d       = id_imm;
      rs1_addr_d  = id_rs1_addr;
      rs2_addr_d  = id_rs2_addr;
      rd_addr_d   = id_rd_addr;
      ctrl_d      = id_alu_ctrl;
      src_a_sel_d = id_src_a_sel;
      src_b_sel_d = id_src_b_sel;
      reg_write_d = id_reg_write;
      mem_read_d  = id_mem_read;
      mem_write_d = id_mem_write;
    end
  end

  // State register; reset wins over everything and leaves control at ADD.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_val_q   <= '0;
      rs2_val_q   <= '0;
      imm_q       <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      ctrl_q      <= CTRL_ADD;
      src_a_sel_q <= 1'b0;
      src_b_sel_q <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_val_q   <= rs1_val_d;
      rs2_val_q   <= rs2_val_d;
      imm_q       <= imm_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rd_addr_q   <= rd_addr_d;
      ctrl_q      <= ctrl_d;
      src_a_sel_q <= src_a_sel_d;
      src_b_sel_q <= src_b_sel_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed scenarios plus a random stream, all
// compared against an instruction-level reference model.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [3:0]  id_alu_ctrl;
  logic        id_src_a_sel, id_src_b_sel, id_reg_write, id_mem_read, id_mem_write;
  logic        stall, flush;
  logic        mem_fwd_en, wb_fwd_en;
  logic [4:0]  mem_fwd_rd, wb_fwd_rd;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        ex_valid;
  logic [31:0] ex_a, ex_b, ex_store_data, ex_pc;
  logic [3:0]  ex_alu_ctrl;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;

  int n_vec = 0;
  int n_err = 0;

  ex_operand_stage #(.DATA_W(32), .CTRL_W(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_alu_ctrl(id_alu_ctrl), .id_src_a_sel(id_src_a_sel), .id_src_b_sel(id_src_b_sel),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .stall(stall), .flush(flush),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  // Reference: the instruction currently sitting in EX.
  typedef struct {
    bit        valid;
    bit        known;   // data fields are defined (not after flush/bubble)
    bit [31:0] pc, r1, r2, imm;
    bit [4:0]  a1, a2, rd;
    bit [3:0]  ctrl;
    bit        sa, sb, rw, mr, mw;
  } instr_t;

  instr_t m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] ref_fwd(input bit [4:0] a, input bit [31:0] held);
    if (a == 0) return held;
    if (mem_fwd_en && mem_fwd_rd == a) return mem_fwd_data;
    if (wb_fwd_en && wb_fwd_rd == a) return wb_fwd_data;
    return held;
  endfunction

  function automatic bit ref_lus();
    return m.valid && m.mr && m.rd != 0 && id_valid &&
           (id_rs1_addr == m.rd || id_rs2_addr == m.rd);
  endfunction

  task automatic idle();
    rst = 0; id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_alu_ctrl = 4'b0010;
    id_src_a_sel = 0; id_src_b_sel = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    stall = 0; flush = 0; mem_fwd_en = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_fwd_en = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
  endtask

  // Let inputs settle and compare every output against the model.
  task automatic settle();
    bit [31:0] f1, f2;
    #1;
    f1 = ref_fwd(m.a1, m.r1);
    f2 = ref_fwd(m.a2, m.r2);
    chk("ex_valid", ex_valid, m.valid);
    chk("ex_reg_write", ex_reg_write, m.valid & m.rw);
    chk("ex_mem_read", ex_mem_read, m.valid & m.mr);
    chk("ex_mem_write", ex_mem_write, m.valid & m.mw);
    chk("load_use_stall", load_use_stall, ref_lus());
    if (m.known) begin
      chk("ex_a", ex_a, m.sa ? m.pc : f1);
      chk("ex_b", ex_b, m.sb ? m.imm : f2);
      chk("ex_store_data", ex_store_data, f2);
      chk("ex_pc", ex_pc, m.pc);
      chk("ex_rd_addr", ex_rd_addr, m.rd);
      chk("ex_alu_ctrl", ex_alu_ctrl, m.ctrl);
    end
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic clk1();
    instr_t n;
    n = m;
    if (rst) begin
      n = '{default: 0};
      n.ctrl = 4'b0010;
      n.known = 1;
    end else if (flush) begin
      n.valid = 0; n.known = 0;
    end else if (stall) begin
      n.r1 = ref_fwd(m.a1, m.r1);
      n.r2 = ref_fwd(m.a2, m.r2);
    end else if (ref_lus()) begin
      n.valid = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.known = 0;
    end else begin
      n.valid = id_valid; n.known = 1;
      n.pc = id_pc; n.r1 = id_rs1_data; n.r2 = id_rs2_data; n.imm = id_imm;
      n.a1 = id_rs1_addr; n.a2 = id_rs2_addr; n.rd = id_rd_addr; n.ctrl = id_alu_ctrl;
      n.sa = id_src_a_sel; n.sb = id_src_b_sel;
      n.rw = id_reg_write; n.mr = id_mem_read; n.mw = id_mem_write;
    end
    @(posedge clk);
    m = n;
    @(negedge clk);
  endtask

  initial begin
    m = '{default: 0};
    idle();
    @(negedge clk);

    // Reset state
    rst = 1; clk1(); rst = 0; settle();
    chk("rst_valid", ex_valid, 0);
    chk("rst_ctrl", ex_alu_ctrl, 32'h2);
    chk("rst_a", ex_a, 0);
    chk("rst_lus", load_use_stall, 0);

    // ADDI x6, x1, 7
    id_valid = 1; id_rs1_addr = 1; id_rs1_data = 5; id_imm = 7; id_alu_ctrl = 4'b0010;
    id_src_b_sel = 1; id_reg_write = 1; id_rd_addr = 6;
    settle(); clk1(); idle(); settle();
    chk("addi_a", ex_a, 5); chk("addi_b", ex_b, 7);
    chk("addi_valid", ex_valid, 1); chk("addi_rw", ex_reg_write, 1);

    // Forward priority on rs1 = x3
    id_valid = 1; id_rs1_addr = 3; id_rs1_data = 1; id_rd_addr = 7;
    settle(); clk1(); idle();
    mem_fwd_en = 1; mem_fwd_rd = 3; mem_fwd_data = 32'hAA;
    wb_fwd_en = 1; wb_fwd_rd = 3; wb_fwd_data = 32'hBB;
    settle(); chk("fwd_mem_prio", ex_a, 32'hAA);
    mem_fwd_en = 0; settle(); chk("fwd_wb", ex_a, 32'hBB);
    // Same through x0: never forwarded
    id_valid = 1; id_rs1_addr = 0; id_rs1_data = 1;
    mem_fwd_en = 0; settle(); clk1();
    idle(); mem_fwd_en = 1; mem_fwd_rd = 0; mem_fwd_data = 32'hAA;
    wb_fwd_en = 1; wb_fwd_rd = 0; wb_fwd_data = 32'hBB;
    settle(); chk("fwd_x0", ex_a, 1);

    // Load-use: LW x4 then ADD x5, x4, x1
    idle(); id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd_addr = 4;
    settle(); clk1();
    idle(); id_valid = 1; id_rs1_addr = 4; id_rs2_addr = 1; id_rd_addr = 5; id_reg_write = 1;
    settle(); chk("lu_stall", load_use_stall, 1);
    clk1(); settle();
    chk("lu_once", load_use_stall, 0); chk("lu_bubble", ex_valid, 0);
    clk1(); idle(); mem_fwd_en = 1; mem_fwd_rd = 4; mem_fwd_data = 32'h44;
    settle(); chk("lu_valid", ex_valid, 1); chk("lu_fwd", ex_a, 32'h44);

    // Stall refresh of rs2 = x2
    idle(); id_valid = 1; id_rs2_addr = 2; id_rs2_data = 0; id_rd_addr = 8;
    settle(); clk1();
    idle(); stall = 1; wb_fwd_en = 1; wb_fwd_rd = 2; wb_fwd_data = 32'h1234;
    settle(); chk("stall_c1", ex_b, 32'h1234); clk1();
    wb_fwd_en = 0; settle(); chk("stall_c2", ex_b, 32'h1234); clk1();
    settle(); chk("stall_c3", ex_b, 32'h1234); clk1();
    stall = 0; settle(); chk("stall_rel", ex_b, 32'h1234); clk1();

    // Flush + stall with a valid store in ID
    idle(); id_valid = 1; id_mem_write = 1; flush = 1; stall = 1;
    settle(); clk1(); idle(); settle();
    chk("flush_valid", ex_valid, 0); chk("flush_mw", ex_mem_write, 0);

    // AUIPC, then reset mid-stream under stall
    id_valid = 1; id_pc = 32'h100; id_imm = 32'h2000; id_src_a_sel = 1; id_src_b_sel = 1;
    id_reg_write = 1; id_rd_addr = 9;
    settle(); clk1(); idle(); settle();
    chk("auipc_a", ex_a, 32'h100); chk("auipc_b", ex_b, 32'h2000);
    rst = 1; stall = 1; clk1(); idle(); settle();
    chk("mrst_valid", ex_valid, 0); chk("mrst_a", ex_a, 0); chk("mrst_b", ex_b, 0);
    chk("mrst_ctrl", ex_alu_ctrl, 32'h2); chk("mrst_pc", ex_pc, 0);
    chk("mrst_rw", ex_reg_write, 0);

    // Random stream with small register indices to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(99) < 2);
      stall        = ($urandom_range(99) < 20);
      flush        = ($urandom_range(99) < 8);
      id_valid     = ($urandom_range(99) < 85);
      id_pc        = $urandom; id_imm = $urandom;
      id_rs1_data  = $urandom; id_rs2_data = $urandom;
      id_rs1_addr  = 5'($urandom_range(3)); id_rs2_addr = 5'($urandom_range(3));
      id_rd_addr   = 5'($urandom_range(3));
      id_alu_ctrl  = 4'($urandom);
      id_src_a_sel = 1'($urandom); id_src_b_sel = 1'($urandom);
      id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(99) < 35);
      id_mem_write = 1'($urandom);
      mem_fwd_en   = 1'($urandom); mem_fwd_rd = 5'($urandom_range(3)); mem_fwd_data = $urandom;
      wb_fwd_en    = 1'($urandom); wb_fwd_rd = 5'($urandom_range(3)); wb_fwd_data = $urandom;
      settle();
      clk1();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
